fibonacci_gen: RTL and testbench

- Fibonacci sequence generator that consumes the `switch` (run/pause) and `clock_sel` (step-rate) controls from the Wishbone control block.
- Drives the user I/O pad bus. The running value sits on io_out[37:8], which the control block reads back as its Fibonacci value register.
- Owns the step-rate prescaler, the 30-bit sequence registers, wrap detection and pad output-enable control.

---
 rtl/fibonacci_gen_pkg.sv | 25 ++
 rtl/fibonacci_gen_if.sv | 23 ++
 rtl/fib_prescaler.sv | 27 ++
 rtl/fibonacci_gen.sv | 59 +++++
 tb/tb_fibonacci_gen.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fibonacci_gen_pkg.sv
// Shared widths, sequence limits and pad mapping for the Fibonacci generator.
package fibonacci_gen_pkg;

   localparam int unsigned IO_PADS     = 38;
   localparam int unsigned VAL_WIDTH   = 30;
   localparam int unsigned VAL_LSB     = 8;
   localparam int unsigned CLOCK_WIDTH = 6;
   localparam int unsigned INDEX_WIDTH = 6;
   localparam int unsigned F_MAX_INDEX = 44;

   localparam logic [VAL_WIDTH-1:0] F_MAX = 30'd701408733;

   // Value pads drive (oeb=0), the lower pads stay as inputs (oeb=1).
   localparam logic [IO_PADS-1:0] IO_OEB_VALUE = {{VAL_WIDTH{1'b0}}, {VAL_LSB{1'b1}}};

   typedef logic [VAL_WIDTH-1:0]   fib_val_t;
   typedef logic [VAL_WIDTH:0]     fib_sum_t;
   typedef logic [INDEX_WIDTH-1:0] fib_index_t;
   typedef logic [CLOCK_WIDTH-1:0] clock_sel_t;

   function automatic logic [IO_PADS-1:0] pad_map(input fib_val_t val);
      return {val, {VAL_LSB{1'b0}}};
   endfunction

endpackage

// File: rtl/fibonacci_gen_if.sv
// Control inputs, pad buses and status pulses between the control block and the generator.
interface fibonacci_gen_if;
   import fibonacci_gen_pkg::*;

   logic               switch;
   clock_sel_t         clock_sel;
   logic [IO_PADS-1:0] io_out;
   logic [IO_PADS-1:0] io_oeb;
   fib_index_t         index;
   logic               step;
   logic               wrap;

   modport master (
      output switch, clock_sel,
      input  io_out, io_oeb, index, step, wrap
   );

   modport slave (
      input  switch, clock_sel,
      output io_out, io_oeb, index, step, wrap
   );

endinterface

// File: rtl/fib_prescaler.sv
// Step-rate prescaler: while enabled, tick_c fires once every clock_sel+1 cycles.
module fib_prescaler #(
   parameter int unsigned WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             switch,
   input  logic [WIDTH-1:0] clock_sel,
   output logic             tick_c
);

   logic [WIDTH-1:0] cnt_q;

   // >= so that lowering clock_sel below the running count ticks right away.
   assign tick_c = switch && (cnt_q >= clock_sel);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!switch || tick_c) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/fibonacci_gen.sv
// Fibonacci sequence generator driving the user pad bus; restarts at F(0) when the next value would overflow.
module fibonacci_gen
   import fibonacci_gen_pkg::*;
(
   input  logic            wb_clk_i,
   input  logic            reset_n,
   fibonacci_gen_if.slave  bus
);

   logic       tick_c;
   fib_val_t   a_q;
   fib_sum_t   b_q;
   fib_index_t index_q;
   logic       step_q;
   logic       wrap_q;

   fib_prescaler #(
      .WIDTH (CLOCK_WIDTH)
   ) u_prescaler (
      .clk       (wb_clk_i),
      .rst_n     (reset_n),
      .switch    (bus.switch),
      .clock_sel (bus.clock_sel),
      .tick_c    (tick_c)
   );

   // a holds F(n), b holds F(n+1) with one guard bit to flag the value that no longer fits.
   always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) begin
         a_q     <= '0;
         b_q     <= fib_sum_t'(1);
         index_q <= '0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         step_q <= tick_c;
         wrap_q <= 1'b0;
         if (tick_c) begin
            if (b_q[VAL_WIDTH]) begin
               a_q     <= '0;
               b_q     <= fib_sum_t'(1);
               index_q <= '0;
               wrap_q  <= 1'b1;
            end else begin
               a_q     <= b_q[VAL_WIDTH-1:0];
               b_q     <= fib_sum_t'(a_q) + b_q;
               index_q <= index_q + fib_index_t'(1);
            end
         end
      end
   end

   assign bus.io_out = pad_map(a_q);
   assign bus.io_oeb = IO_OEB_VALUE;
   assign bus.index  = index_q;
   assign bus.step   = step_q;
   assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_fibonacci_gen.sv
// Self-checking bench for fibonacci_gen: directed scenarios plus randomized control against a table-driven model.
module tb_fibonacci_gen;
   import fibonacci_gen_pkg::*;

   logic wb_clk_i = 1'b0;
   logic reset_n  = 1'b0;

   fibonacci_gen_if bus ();

   fibonacci_gen dut (
      .wb_clk_i (wb_clk_i),
      .reset_n  (reset_n),
      .bus      (bus)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int checks = 0;
   int errors = 0;

   // Reference: Fibonacci table plus the step/index bookkeeping.
   logic [29:0] fib [0:44];
   int  m_cnt  = 0;
   int  m_idx  = 0;
   bit  m_step = 1'b0;
   bit  m_wrap = 1'b0;
   int  m_wraps = 0;
   bit  m_tick;

   always @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) begin
         m_cnt  = 0;
         m_idx  = 0;
         m_step = 1'b0;
         m_wrap = 1'b0;
      end else begin
         m_tick = bus.switch && (m_cnt >= int'(bus.clock_sel));
         m_cnt  = (!bus.switch || m_tick) ? 0 : m_cnt + 1;
         m_step = m_tick;
         m_wrap = 1'b0;
         if (m_tick) begin
            if (m_idx == int'(F_MAX_INDEX)) begin
               m_idx  = 0;
               m_wrap = 1'b1;
               m_wraps++;
            end else begin
               m_idx++;
            end
         end
      end
   end

   function automatic logic [37:0] exp_io();
      return {fib[m_idx], 8'h00};
   endfunction

   task automatic apply_reset();
      @(negedge wb_clk_i);
      bus.switch    = 1'b0;
      bus.clock_sel = '0;
      reset_n       = 1'b0;
      @(negedge wb_clk_i);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.switch    = 1'b0;
      bus.clock_sel = '0;
      reset_n       = 1'b0;
      #12;
      checks++;
      if (bus.io_out !== 38'h0) begin errors++; $display("FAIL reset_io_out: got %h expected 0", bus.io_out); end
      checks++;
      if (bus.index !== 6'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", bus.index); end
      checks++;
      if (bus.step !== 1'b0 || bus.wrap !== 1'b0) begin
         errors++; $display("FAIL reset_pulses: got step=%b wrap=%b expected 0 0", bus.step, bus.wrap);
      end
      checks++;
      if (bus.io_oeb !== 38'h00_0000_00FF) begin errors++; $display("FAIL io_oeb: got %h expected 00000000ff", bus.io_oeb); end
      @(negedge wb_clk_i);
      reset_n = 1'b1;
   endtask

   task automatic test_run_fast();
      apply_reset();
      bus.clock_sel = 6'd0;
      bus.switch    = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge wb_clk_i);
         checks++;
         if (bus.step !== 1'b1) begin errors++; $display("FAIL fast_step cycle %0d: got %b expected 1", i, bus.step); end
         checks++;
         if (bus.io_out !== exp_io()) begin errors++; $display("FAIL fast_value cycle %0d: got %h expected %h", i, bus.io_out, exp_io()); end
      end
      checks++;
      if (bus.index !== 6'd10) begin errors++; $display("FAIL fast_index: got %0d expected 10", bus.index); end
      checks++;
      if (bus.io_out[37:8] !== 30'd55) begin errors++; $display("FAIL fast_f10: got %0d expected 55", bus.io_out[37:8]); end
   endtask

   task automatic test_rate();
      apply_reset();
      bus.clock_sel = 6'd3;
      bus.switch    = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge wb_clk_i);
         checks++;
         if (bus.step !== ((k % 4) == 0)) begin
            errors++; $display("FAIL rate_step cycle %0d: got %b expected %b", k, bus.step, (k % 4) == 0);
         end
      end
      checks++;
      if (bus.io_out[37:8] !== 30'd5 || bus.index !== 6'd5) begin
         errors++; $display("FAIL rate_value: got %0d idx %0d expected 5 idx 5", bus.io_out[37:8], bus.index);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      bus.clock_sel = 6'd0;
      bus.switch    = 1'b1;
      for (int i = 1; i <= 44; i++) begin
         @(negedge wb_clk_i);
         checks++;
         if (bus.wrap !== 1'b0) begin errors++; $display("FAIL wrap_early cycle %0d: got %b expected 0", i, bus.wrap); end
      end
      checks++;
      if (bus.io_out[37:8] !== F_MAX || bus.index !== 6'd44) begin
         errors++; $display("FAIL wrap_fmax: got %0d idx %0d expected %0d idx 44", bus.io_out[37:8], bus.index, F_MAX);
      end
      @(negedge wb_clk_i);
      checks++;
      if (bus.io_out !== 38'h0 || bus.index !== 6'd0 || bus.wrap !== 1'b1 || bus.step !== 1'b1) begin
         errors++; $display("FAIL wrap_restart: got val %0d idx %0d wrap %b step %b expected 0 0 1 1",
                            bus.io_out[37:8], bus.index, bus.wrap, bus.step);
      end
      @(negedge wb_clk_i);
      checks++;
      if (bus.io_out[37:8] !== 30'd1 || bus.index !== 6'd1 || bus.wrap !== 1'b0) begin
         errors++; $display("FAIL wrap_after: got val %0d idx %0d wrap %b expected 1 1 0",
                            bus.io_out[37:8], bus.index, bus.wrap);
      end
   endtask

   task automatic test_pause();
      apply_reset();
      bus.clock_sel = 6'd0;
      bus.switch    = 1'b1;
      repeat (8) @(negedge wb_clk_i);
      checks++;
      if (bus.io_out[37:8] !== 30'd21) begin errors++; $display("FAIL pause_start: got %0d expected 21", bus.io_out[37:8]); end
      bus.switch = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge wb_clk_i);
         checks++;
         if (bus.io_out[37:8] !== 30'd21 || bus.index !== 6'd8 || bus.step !== 1'b0) begin
            errors++; $display("FAIL pause_hold cycle %0d: got val %0d idx %0d step %b expected 21 8 0",
                               i, bus.io_out[37:8], bus.index, bus.step);
         end
      end
      bus.clock_sel = 6'd2;
      bus.switch    = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge wb_clk_i);
         checks++;
         if (bus.step !== (k == 3)) begin errors++; $display("FAIL resume_step cycle %0d: got %b expected %b", k, bus.step, k == 3); end
      end
      checks++;
      if (bus.io_out[37:8] !== 30'd34) begin errors++; $display("FAIL resume_value: got %0d expected 34", bus.io_out[37:8]); end
   endtask

   task automatic test_rate_change();
      apply_reset();
      bus.clock_sel = 6'd40;
      bus.switch    = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge wb_clk_i);
         checks++;
         if (bus.step !== 1'b0) begin errors++; $display("FAIL slow_step cycle %0d: got %b expected 0", i, bus.step); end
      end
      bus.clock_sel = 6'd5;
      @(negedge wb_clk_i);
      checks++;
      if (bus.step !== 1'b1 || bus.index !== 6'd1) begin
         errors++; $display("FAIL lower_sel_tick: got step %b idx %0d expected 1 1", bus.step, bus.index);
      end
      for (int k = 1; k <= 12; k++) begin
         @(negedge wb_clk_i);
         checks++;
         if (bus.step !== ((k % 6) == 0)) begin
            errors++; $display("FAIL period6_step cycle %0d: got %b expected %b", k, bus.step, (k % 6) == 0);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [29:0] seq [3];
      seq = '{30'd1, 30'd1, 30'd2};
      apply_reset();
      bus.clock_sel = 6'd0;
      bus.switch    = 1'b1;
      repeat (30) @(negedge wb_clk_i);
      checks++;
      if (bus.index !== 6'd30) begin errors++; $display("FAIL areset_pre: got idx %0d expected 30", bus.index); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.io_out !== 38'h0 || bus.index !== 6'd0 || bus.step !== 1'b0 || bus.wrap !== 1'b0) begin
         errors++; $display("FAIL areset_now: got val %0d idx %0d step %b wrap %b expected all 0",
                            bus.io_out[37:8], bus.index, bus.step, bus.wrap);
      end
      @(negedge wb_clk_i);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge wb_clk_i);
         checks++;
         if (bus.io_out[37:8] !== seq[i] || bus.index !== 6'(i + 1)) begin
            errors++; $display("FAIL areset_seq %0d: got val %0d idx %0d expected %0d idx %0d",
                               i, bus.io_out[37:8], bus.index, seq[i], i + 1);
         end
      end
   endtask

   task automatic test_random();
      int wraps_before;
      apply_reset();
      wraps_before  = m_wraps;
      bus.switch    = 1'b1;
      bus.clock_sel = 6'($urandom_range(0, 3));
      for (int i = 0; i < 3000; i++) begin
         @(negedge wb_clk_i);
         checks++;
         if (bus.io_out !== exp_io() || bus.index !== 6'(m_idx) ||
             bus.step !== m_step || bus.wrap !== m_wrap) begin
            errors++; $display("FAIL random cycle %0d: got val %0d idx %0d step %b wrap %b expected %0d %0d %b %b",
                               i, bus.io_out[37:8], bus.index, bus.step, bus.wrap,
                               fib[m_idx], m_idx, m_step, m_wrap);
         end
         if ($urandom_range(0, 99) < 3) bus.switch = ~bus.switch;
         if ($urandom_range(0, 99) < 4) begin
            if ($urandom_range(0, 9) == 0) bus.clock_sel = 6'($urandom_range(0, 63));
            else                           bus.clock_sel = 6'($urandom_range(0, 4));
         end
      end
      checks++;
      if (m_wraps == wraps_before) begin errors++; $display("FAIL random_wrap_seen: got 0 wraps expected at least 1"); end
   endtask

   initial begin
      longint f0, f1, ft;
      f0 = 0;
      f1 = 1;
      for (int i = 0; i <= 44; i++) begin
         fib[i] = 30'(f0);
         ft = f0 + f1;
         f0 = f1;
         f1 = ft;
      end
      test_reset();
      test_run_fast();
      test_rate();
      test_wrap();
      test_pause();
      test_rate_change();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
